// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encodings, opcodes, ALU codes, trap causes and control vector
package cpu_pkg;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SUBU = 3'b100;
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_OVF     = 2'b11;
  typedef struct packed {
    logic       ext_op;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       r_type;
    logic       branch;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_wr;
  } ctrl_t;
  // j is handled separately in DECODE, so it is not part of the EXEC-bound set
  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_ORI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ};
  endfunction
endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode to control-vector decoder
module mc_decode
  import cpu_pkg::*;
(
  input  logic [5:0] op,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl            = '0;
    ctrl.r_type     = op == OP_R;
    ctrl.reg_dst    = op == OP_R;
    ctrl.alu_src    = op inside {OP_ORI, OP_ADDIU, OP_LW, OP_SW};
    ctrl.ext_op     = op inside {OP_ADDIU, OP_LW, OP_SW};
    ctrl.alu_op     = op == OP_ORI ? ALU_OR : op == OP_BEQ ? ALU_SUBU : ALU_ADDU;
    ctrl.branch     = op == OP_BEQ;
    ctrl.mem_to_reg = op == OP_LW;
    ctrl.mem_wr     = op == OP_SW;
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle CPU control FSM with memory wait timeout, traps and retire counter
module mc_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             Zero,
  input  logic             Overflow,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_wr,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             pc_jump,
  output logic             ExtOp,
  output logic             ALUsrc,
  output logic [2:0]       ALUOp,
  output logic             R_type,
  output logic             RegDst,
  output logic             Branch,
  output logic             MemtoReg,
  output logic             RegWr,
  output logic             dmem_req,
  output logic             MemWr,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_cnt
);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [5:0] op_q;
  logic ov_q;
  logic [7:0] wait_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0] cause_q, cause_d;
  logic ready, expire, ovf, retire, alu_on;
  ctrl_t c;
  mc_decode u_decode (.op(op_q), .ctrl(c));
  assign ready  = state_q == MEM ? dmem_ready : imem_ready;
  // the wait that would bring the counter to TIMEOUT is the one that traps, unless ready wins
  assign expire = !ready && wait_q == WAIT_LAST;
  assign ovf    = ov_q && op_q == OP_R;
  assign retire = (state_q == DECODE && opcode == OP_J) || (state_q == EXEC && op_q == OP_BEQ) ||
                  (state_q == MEM && dmem_ready && op_q == OP_SW) || (state_q == WB && !ovf);
  assign cause_d = state_d != TRAP || state_q == TRAP ? cause_q :
                   state_q == DECODE ? CAUSE_ILLEGAL :
                   state_q == WB ? CAUSE_OVF :
                   state_q inside {FETCH, MEM} ? CAUSE_TIMEOUT : cause_q;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) state_q <= FETCH;
    else state_q <= state_d;
  always_comb begin
    state_d = TRAP;
    case (state_q)
      FETCH:   state_d = imem_ready ? DECODE : expire ? TRAP : FETCH;
      DECODE:  state_d = opcode == OP_J ? FETCH : is_legal(opcode) ? EXEC : TRAP;
      EXEC:    state_d = op_q == OP_BEQ ? FETCH : op_q inside {OP_LW, OP_SW} ? MEM : WB;
      MEM:     state_d = dmem_ready ? (op_q == OP_SW ? FETCH : WB) : expire ? TRAP : MEM;
      WB:      state_d = ovf ? TRAP : FETCH;
      default: state_d = TRAP;
    endcase
  end
  assign alu_on = state_q inside {EXEC, WB};
  always_comb begin
    imem_req  = state_q == FETCH;
    ir_wr     = imem_req && imem_ready;
    pc_inc    = imem_req && imem_ready;
    pc_jump   = state_q == DECODE && opcode == OP_J;
    pc_branch = state_q == EXEC && c.branch && Zero;
    ExtOp     = alu_on && c.ext_op;
    ALUsrc    = alu_on && c.alu_src;
    ALUOp     = alu_on ? c.alu_op : ALU_ADDU;
    R_type    = alu_on && c.r_type;
    Branch    = state_q == EXEC && c.branch;
    RegDst    = state_q == WB && c.reg_dst;
    MemtoReg  = state_q == WB && c.mem_to_reg;
    RegWr     = state_q == WB && !ovf;
    dmem_req  = state_q == MEM;
    MemWr     = dmem_req && c.mem_wr;
    trap      = state_q == TRAP;
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      op_q    <= '0;
      ov_q    <= 1'b0;
      wait_q  <= '0;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      cause_q <= cause_d;
      if (retire) cnt_q <= cnt_q + 1'b1;
      if (state_q == DECODE) op_q <= opcode;
      if (state_q == EXEC) ov_q <= Overflow;
      wait_q <= state_d != state_q && state_d inside {FETCH, MEM} ? 8'd0 :
                state_q inside {FETCH, MEM} && !ready ? wait_q + 8'd1 : wait_q;
    end
  assign state      = state_q;
  assign trap_cause = cause_q;
  assign instr_cnt  = cnt_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized and directed checks of mc_ctrl against a behavioural instruction model
module tb_mc_ctrl;
  localparam int TO = 255;
  localparam int CW = 4;
  localparam logic [5:0] R = 6'b000000, J = 6'b000010, BEQ = 6'b000100, ADDIU = 6'b001001;
  localparam logic [5:0] ORI = 6'b001101, LW = 6'b100011, SW = 6'b101011;
  logic clock = 0, rst_n = 0;
  logic [5:0] opcode = '0;
  logic Zero = 0, Overflow = 0, imem_ready = 0, dmem_ready = 0;
  logic imem_req, ir_wr, pc_inc, pc_branch, pc_jump, ExtOp, ALUsrc, R_type, RegDst, Branch;
  logic MemtoReg, RegWr, dmem_req, MemWr, trap;
  logic [2:0] ALUOp, state;
  logic [1:0] trap_cause;
  logic [CW-1:0] instr_cnt;
  int checks = 0, failures = 0;
  int m_st, m_wait, m_cnt;
  logic [5:0] m_op;
  bit m_ov;
  logic [1:0] m_cause;
  logic [2:0] s_st;
  logic s_regwr, s_m2r, s_dreq, s_pcb, s_trap;
  logic [5:0] legal_ops [6] = '{R, ORI, ADDIU, LW, SW, BEQ};

  mc_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .rst_n(rst_n), .opcode(opcode), .Zero(Zero), .Overflow(Overflow),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_wr(ir_wr),
    .pc_inc(pc_inc), .pc_branch(pc_branch), .pc_jump(pc_jump), .ExtOp(ExtOp), .ALUsrc(ALUsrc),
    .ALUOp(ALUOp), .R_type(R_type), .RegDst(RegDst), .Branch(Branch), .MemtoReg(MemtoReg),
    .RegWr(RegWr), .dmem_req(dmem_req), .MemWr(MemWr), .state(state), .trap(trap),
    .trap_cause(trap_cause), .instr_cnt(instr_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1;
    return 0;
  endfunction

  // what the control word must be for the instruction held in m_op, by instruction class
  function automatic logic [17:0] exp_vec();
    logic [2:0] aop;
    bit ext, src, rt, br, fe, de, ex, me, wb, alu, ovf_r;
    {ext, src, aop, rt, br} = '0;
    case (m_op)
      R:              {ext, src, aop, rt, br} = {1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
      ORI:            {ext, src, aop, rt, br} = {1'b0, 1'b1, 3'b010, 1'b0, 1'b0};
      ADDIU, LW, SW:  {ext, src, aop, rt, br} = {1'b1, 1'b1, 3'b000, 1'b0, 1'b0};
      BEQ:            {ext, src, aop, rt, br} = {1'b0, 1'b0, 3'b100, 1'b0, 1'b1};
      default:        ;
    endcase
    fe = m_st == 0; de = m_st == 1; ex = m_st == 2; me = m_st == 3; wb = m_st == 4;
    alu = ex || wb;
    ovf_r = m_ov && m_op == R;
    return {fe, fe && imem_ready, fe && imem_ready, ex && br && Zero, de && opcode == J,
            alu && ext, alu && src, alu ? aop : 3'b000, alu && rt, wb && m_op == R, ex && br,
            wb && m_op == LW, wb && !ovf_r, me, me && m_op == SW, m_st == 5};
  endfunction

  task automatic model_reset();
    m_st = 0; m_wait = 0; m_cnt = 0; m_op = '0; m_ov = 0; m_cause = 2'b00;
  endtask

  task automatic model_step();
    int nx;
    bit ret;
    nx = m_st; ret = 0;
    case (m_st)
      0: if (imem_ready) nx = 1;
         else begin if (m_wait + 1 == TO) begin nx = 5; m_cause = 2'b10; end m_wait++; end
      1: begin
        m_op = opcode;
        if (opcode == J) begin nx = 0; ret = 1; end
        else if (is_legal(opcode)) nx = 2;
        else begin nx = 5; m_cause = 2'b01; end
      end
      2: begin
        m_ov = Overflow;
        nx = m_op == BEQ ? 0 : (m_op == LW || m_op == SW) ? 3 : 4;
        ret = m_op == BEQ;
      end
      3: if (dmem_ready) begin nx = m_op == SW ? 0 : 4; ret = m_op == SW; end
         else begin if (m_wait + 1 == TO) begin nx = 5; m_cause = 2'b10; end m_wait++; end
      4: if (m_ov && m_op == R) begin nx = 5; m_cause = 2'b11; end
         else begin nx = 0; ret = 1; end
      default: nx = 5;
    endcase
    if (ret) m_cnt = (m_cnt + 1) % (1 << CW);
    if (nx != m_st && (nx == 0 || nx == 3)) m_wait = 0;
    m_st = nx;
  endtask

  task automatic cyc(input logic [5:0] op, input logic z, input logic ov, input logic ir, input logic dr);
    opcode = op; Zero = z; Overflow = ov; imem_ready = ir; dmem_ready = dr;
    @(negedge clock);
    chk("state", state, m_st);
    chk("outputs", exp_vec(), {imem_req, ir_wr, pc_inc, pc_branch, pc_jump, ExtOp, ALUsrc, ALUOp,
        R_type, RegDst, Branch, MemtoReg, RegWr, dmem_req, MemWr, trap});
    chk("trap_cause", trap_cause, m_cause);
    chk("instr_cnt", instr_cnt, m_cnt);
    {s_st, s_regwr, s_m2r, s_dreq, s_pcb, s_trap} = {state, RegWr, MemtoReg, dmem_req, pc_branch, trap};
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_state", state, 0);
    chk("rst_cnt", instr_cnt, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_imem_req", imem_req, 1);
    @(posedge clock);
    #1 rst_n = 1;
  endtask

  initial begin
    logic [14:0] path;
    logic [3:0] rw;
    int n;
    #2 do_reset();
    path = '0; rw = '0;
    cyc(R, 0, 0, 1, 0);     path = {path[11:0], s_st}; rw = {rw[2:0], s_regwr};
    cyc(ADDIU, 0, 0, 0, 0); path = {path[11:0], s_st}; rw = {rw[2:0], s_regwr};
    cyc(R, 0, 0, 0, 0);     path = {path[11:0], s_st}; rw = {rw[2:0], s_regwr};
    cyc(R, 0, 0, 0, 0);     path = {path[11:0], s_st}; rw = {rw[2:0], s_regwr};
    path = {path[11:0], state};
    chk("addiu_path", path, {3'd0, 3'd1, 3'd2, 3'd4, 3'd0});
    chk("addiu_regwr", rw, 4'b0001);
    chk("addiu_cnt", instr_cnt, 1);
    cyc(R, 0, 0, 1, 0); cyc(LW, 0, 0, 0, 0); cyc(R, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin cyc(R, 0, 0, 0, i == 3); n += int'(s_dreq && s_st == 3'd3); end
    chk("lw_mem_cycles", n, 4);
    cyc(R, 0, 0, 0, 0);
    chk("lw_wb", {s_st, s_m2r, s_regwr}, {3'd4, 1'b1, 1'b1});
    cyc(R, 0, 0, 1, 0); cyc(BEQ, 0, 0, 0, 0); cyc(R, 1, 0, 0, 0);
    chk("beq_taken", s_pcb, 1);
    cyc(R, 0, 0, 1, 0); cyc(BEQ, 0, 0, 0, 0); cyc(R, 0, 0, 0, 0);
    chk("beq_not_taken", {s_pcb, state}, {1'b0, 3'd0});
    chk("seq_cnt", instr_cnt, 4);
    cyc(R, 0, 0, 1, 0); cyc(6'b111111, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin cyc(R, 0, 0, 1, 1); n += int'(s_st == 3'd5 && s_trap); end
    chk("illegal_hold", n, 10);
    chk("illegal_cause", trap_cause, 2'b01);
    do_reset();
    chk("illegal_exit", state, 0);
    cyc(R, 0, 0, 1, 0); cyc(R, 0, 0, 0, 0); cyc(R, 0, 1, 0, 0); cyc(R, 0, 0, 0, 0);
    chk("ovf_regwr", s_regwr, 0);
    chk("ovf_trap", {state, trap_cause, instr_cnt}, {3'd5, 2'b11, 4'd0});
    do_reset();
    for (int i = 0; i < 255; i++) cyc(R, 0, 0, 0, 0);
    chk("imem_timeout", {state, trap_cause}, {3'd5, 2'b10});
    do_reset();
    for (int i = 0; i < 254; i++) cyc(R, 0, 0, 0, 0);
    cyc(R, 0, 0, 1, 0);
    chk("imem_ready_wins", {state, trap_cause}, {3'd1, 2'b00});
    do_reset();
    cyc(R, 0, 0, 1, 0); cyc(SW, 0, 0, 0, 0); cyc(R, 0, 0, 0, 0);
    for (int i = 0; i < 255; i++) cyc(R, 0, 0, 0, 0);
    chk("dmem_timeout", {state, trap_cause}, {3'd5, 2'b10});
    do_reset();
    for (int i = 0; i < 15; i++) begin cyc(R, 0, 0, 1, 0); cyc(J, 0, 0, 0, 0); end
    chk("cnt_15", instr_cnt, 15);
    cyc(R, 0, 0, 1, 0); cyc(J, 0, 0, 0, 0);
    chk("cnt_wrap", instr_cnt, 0);
    cyc(R, 0, 0, 1, 0); cyc(J, 0, 0, 0, 0);
    chk("cnt_after_wrap", instr_cnt, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      int r;
      r = $urandom_range(0, 19);
      op = r < 16 ? legal_ops[r % 6] : r < 18 ? J : 6'($urandom);
      if ((m_st == 5 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) do_reset();
      else cyc(op, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles a memory request waits before trap.
REQ-002 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; ports: clock in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-004 SHALL have these inputs: opcode in 6, instruction[31:26]; Zero in 1, ALU zero; Overflow in 1, ALU signed overflow; imem_ready in 1, instruction-memory acknowledge; dmem_ready in 1, data-memory acknowledge.
REQ-005 SHALL have these fetch and PC outputs: imem_req out 1; ir_wr out 1, instruction register load; pc_inc out 1, PC<=PC+4; pc_branch out 1, PC<=newPC; pc_jump out 1, PC<=jump target.
REQ-006 SHALL have these execute-unit controls: ExtOp out 1; ALUsrc out 1; ALUOp out 3; R_type out 1; RegDst out 1; Branch out 1; MemtoReg out 1; RegWr out 1.
REQ-007 SHALL have these memory and status outputs: dmem_req out 1; MemWr out 1; state out 3; trap out 1; trap_cause out 2 (01 illegal, 10 timeout, 11 overflow); instr_cnt out CNT_W.

Function
REQ-008 SHALL sequence states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to TRAP.
REQ-009 FETCH: imem_req=1; on imem_ready it SHALL pulse ir_wr and pc_inc for one cycle, then go to DECODE; otherwise it SHALL stay in FETCH.
REQ-010 DECODE: SHALL latch opcode into op_q.
REQ-011 DECODE transitions: 000010 (j) SHALL pulse pc_jump, increment instr_cnt, and go to FETCH; the legal set {000000 R, 001101 ori, 001001 addiu, 100011 lw, 101011 sw, 000100 beq} SHALL go to EXEC; any other opcode SHALL go to TRAP with cause 01.
REQ-012 EXEC controls by op_q: R SHALL drive R_type=1, ALUsrc=0; ori SHALL drive ALUOp=010, ALUsrc=1, ExtOp=0; addiu/lw/sw SHALL drive ALUOp=000, ALUsrc=1, ExtOp=1; beq SHALL drive ALUOp=100, ALUsrc=0, Branch=1.
REQ-013 EXEC latching: SHALL register Overflow into ov_q.
REQ-014 EXEC beq: SHALL assert pc_branch=Zero, increment instr_cnt, and go to FETCH.
REQ-015 EXEC next state: lw/sw SHALL go to MEM; R/ori/addiu SHALL go to WB.
REQ-016 MEM: dmem_req=1, with MemWr=1 only for sw; on dmem_ready, sw SHALL retire and go to FETCH and lw SHALL go to WB.
REQ-017 WB: RegWr=1; RegDst=1 for R only; MemtoReg=1 for lw only; ALU controls SHALL hold their EXEC values; WB SHALL retire and go to FETCH.
REQ-018 Overflow trap: if ov_q=1 and op_q=R, RegWr SHALL be 0 in WB and the next state SHALL be TRAP with cause 11; no increment.
REQ-019 Outputs not named for the current state SHALL be 0.
REQ-020 All outputs SHALL be combinational from state and op_q.
REQ-021 pc_*, ir_wr and MemWr SHALL be single-cycle per event, except that MemWr SHALL hold while waiting.
REQ-022 An 8-bit wait counter SHALL clear on entering FETCH or MEM and increment each cycle ready is low.
REQ-023 When the wait counter reaches TIMEOUT with ready still low, the controller SHALL go to TRAP with cause 10.
REQ-024 Ready arriving in the same cycle as the timeout SHALL win: no trap.
REQ-025 TRAP SHALL be absorbing: trap=1, all strobes 0, and only reset exits it.
REQ-026 instr_cnt SHALL wrap from 2^CNT_W-1 to 0.

Reset
REQ-027 On rst_n low, asynchronously: state=FETCH, op_q=0, ov_q=0, wait counter=0, instr_cnt=0, trap_cause=00.
REQ-028 Reset mid-operation SHALL abandon any outstanding request: imem_req becomes 1 in the first cycle after release.

Structure
REQ-029 State encodings, opcode constants, ALUOp codes (ADDU 000, OR 010, SUBU 100) and trap causes SHALL live in shared package cpu_pkg.
REQ-030 One sub-module, mc_decode (combinational op_q -> control vector), SHALL be instantiated; FSM and counters SHALL stay in mc_ctrl.

Verification
REQ-031 addiu with imem_ready=1 in FETCH SHALL visit states 0,1,2,4,0 in 4 cycles, with RegWr=1 only in WB and instr_cnt=1.
REQ-032 lw with dmem_ready held low 3 cycles SHALL keep MEM for 4 cycles with dmem_req=1, then WB with MemtoReg=1 and RegWr=1.
REQ-033 beq with Zero=1 SHALL assert pc_branch in EXEC; with Zero=0, pc_branch SHALL be 0 and the next state SHALL be FETCH.
REQ-034 opcode 111111 SHALL give trap=1 with trap_cause=01; state SHALL stay 5 for 10 cycles and return to 0 after an rst_n pulse.
REQ-035 imem_ready low for 255 cycles SHALL give TRAP with cause 10; ready at cycle 255 SHALL give DECODE.
REQ-036 R-type with Overflow=1 in EXEC SHALL give RegWr=0 in WB, then TRAP with cause 11; instr_cnt SHALL be unchanged.
